// File: rtl/sigma_tile_sched_if.sv
// Handshake bundle between the SIGMA tile scheduler, the tile fetch front-end
// and the control generator / distribution network.
interface sigma_tile_sched_if #(
    parameter int LOG2_PES         = 5,
    parameter int LOG2_W_BUFF_SIZE = 6,
    parameter int LOG2_I_COL_SIZE  = 3
);
    logic                                   tile_valid;
    logic                                   tile_ready;
    logic [LOG2_W_BUFF_SIZE:0]              tile_w_nnz;
    logic [LOG2_I_COL_SIZE:0]               tile_i_cols;
    logic                                   tile_last;
    logic                                   load_en;
    logic [LOG2_W_BUFF_SIZE-LOG2_PES-1:0]   fold_idx;
    logic [LOG2_PES:0]                      fold_nnz;
    logic                                   col_valid;
    logic                                   col_ready;
    logic [LOG2_I_COL_SIZE-1:0]             col_idx;
    logic                                   done_computing_one_tile;
    logic                                   tile_done;
    logic                                   all_done;
    logic                                   busy;
    logic [15:0]                            stall_cnt;

    modport master (
        input  tile_valid, tile_w_nnz, tile_i_cols, tile_last,
               col_ready, done_computing_one_tile,
        output tile_ready, load_en, fold_idx, fold_nnz, col_valid, col_idx,
               tile_done, all_done, busy, stall_cnt
    );

    modport slave (
        output tile_valid, tile_w_nnz, tile_i_cols, tile_last,
               col_ready, done_computing_one_tile,
        input  tile_ready, load_en, fold_idx, fold_nnz, col_valid, col_idx,
               tile_done, all_done, busy, stall_cnt
    );
endinterface

// File: rtl/sigma_tile_sched.sv
// SIGMA tile scheduler: accepts one descriptor, then sequences stationary load,
// column streaming and reduction drain per fold of NUM_PES non-zeros.
module sigma_tile_sched #(
    parameter int NUM_PES          = 32,
    parameter int LOG2_PES         = 5,
    parameter int W_BUFF_SIZE      = 64,
    parameter int LOG2_W_BUFF_SIZE = 6,
    parameter int I_COL_SIZE       = 8,
    parameter int LOG2_I_COL_SIZE  = 3,
    parameter int LOAD_LAT         = 1
) (
    input  logic                clk,
    input  logic                rst,
    sigma_tile_sched_if.master  sched_io
);
    localparam int FW = LOG2_W_BUFF_SIZE - LOG2_PES;
    localparam int NW = LOG2_W_BUFF_SIZE + 1;
    localparam int CW = LOG2_I_COL_SIZE + 1;

    localparam logic [NW-1:0]       W_MAX    = NW'(W_BUFF_SIZE);
    localparam logic [CW-1:0]       C_MAX    = CW'(I_COL_SIZE);
    localparam logic [NW-1:0]       PES_N    = NW'(NUM_PES);
    localparam logic [NW-1:0]       PES_M1   = NW'(NUM_PES - 1);
    localparam logic [LOG2_PES:0]   PES_CAP  = (LOG2_PES+1)'(NUM_PES);
    localparam logic [2:0]          LAT_LAST = 3'(LOAD_LAT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_LWAIT  = 3'd2;
    localparam logic [2:0] S_STREAM = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]                 state_q, state_d;
    logic [NW-1:0]              nnz_q, nnz_d;
    logic [CW-1:0]              cols_q, cols_d;
    logic                       last_q, last_d;
    logic [FW:0]                num_folds_q, num_folds_d;
    logic [FW-1:0]              fold_q, fold_d;
    logic [LOG2_PES:0]          fold_nnz_q, fold_nnz_d;
    logic [LOG2_I_COL_SIZE-1:0] col_idx_q, col_idx_d;
    logic [2:0]                 wait_q, wait_d;
    logic [15:0]                stall_q, stall_d;

    logic tile_ready_q, load_en_q, col_valid_q, tile_done_q, all_done_q, busy_q;

    logic [NW-1:0] nnz_in;
    logic [CW-1:0] cols_in;
    logic [FW:0]   folds_in;
    logic [NW-1:0] remaining;
    logic          col_last;
    logic          fold_last;

    // Out-of-range descriptors are clamped to the buffer capacities
    assign nnz_in    = (sched_io.tile_w_nnz > W_MAX) ? W_MAX : sched_io.tile_w_nnz;
    assign cols_in   = (sched_io.tile_i_cols > C_MAX) ? C_MAX : sched_io.tile_i_cols;
    assign folds_in  = (FW+1)'((nnz_in + PES_M1) >> LOG2_PES);
    assign col_last  = (({1'b0, col_idx_q} + CW'(1)) == cols_q);
    assign fold_last = (({1'b0, fold_q} + (FW+1)'(1)) == num_folds_q);

    always_comb begin
        state_d     = state_q;
        nnz_d       = nnz_q;
        cols_d      = cols_q;
        last_d      = last_q;
        num_folds_d = num_folds_q;
        fold_d      = fold_q;
        col_idx_d   = col_idx_q;
        wait_d      = wait_q;
        case (state_q)
            S_IDLE: begin
                if (sched_io.tile_valid && tile_ready_q) begin
                    nnz_d       = nnz_in;
                    cols_d      = cols_in;
                    last_d      = sched_io.tile_last;
                    num_folds_d = folds_in;
                    if (nnz_in == '0 || cols_in == '0) begin
                        state_d = S_DONE;
                    end else begin
                        fold_d  = '0;
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                col_idx_d = '0;
                wait_d    = '0;
                state_d   = (LOAD_LAT > 0) ? S_LWAIT : S_STREAM;
            end
            S_LWAIT: begin
                if (wait_q == LAT_LAST) state_d = S_STREAM;
                else                    wait_d  = wait_q + 3'd1;
            end
            S_STREAM: begin
                if (sched_io.col_ready) begin
                    if (col_last) state_d   = S_DRAIN;
                    else          col_idx_d = col_idx_q + LOG2_I_COL_SIZE'(1);
                end
            end
            S_DRAIN: begin
                if (sched_io.done_computing_one_tile) begin
                    if (fold_last) begin
                        state_d = S_DONE;
                    end else begin
                        fold_d  = fold_q + FW'(1);
                        state_d = S_LOAD;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Fold size is fixed on entry to LOAD and then held through DRAIN
    always_comb begin
        remaining  = nnz_d - {1'b0, fold_d, {LOG2_PES{1'b0}}};
        fold_nnz_d = fold_nnz_q;
        if (state_d == S_LOAD)
            fold_nnz_d = (remaining > PES_N) ? PES_CAP : remaining[LOG2_PES:0];
    end

    assign stall_d = (col_valid_q && !sched_io.col_ready && stall_q != 16'hFFFF)
                     ? stall_q + 16'd1 : stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            nnz_q        <= '0;
            cols_q       <= '0;
            last_q       <= 1'b0;
            num_folds_q  <= '0;
            fold_q       <= '0;
            fold_nnz_q   <= '0;
            col_idx_q    <= '0;
            wait_q       <= '0;
            stall_q      <= '0;
            tile_ready_q <= 1'b1;
            load_en_q    <= 1'b0;
            col_valid_q  <= 1'b0;
            tile_done_q  <= 1'b0;
            all_done_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            nnz_q        <= nnz_d;
            cols_q       <= cols_d;
            last_q       <= last_d;
            num_folds_q  <= num_folds_d;
            fold_q       <= fold_d;
            fold_nnz_q   <= fold_nnz_d;
            col_idx_q    <= col_idx_d;
            wait_q       <= wait_d;
            stall_q      <= stall_d;
            tile_ready_q <= (state_d == S_IDLE);
            load_en_q    <= (state_d == S_LOAD);
            col_valid_q  <= (state_d == S_STREAM);
            tile_done_q  <= (state_d == S_DONE);
            all_done_q   <= (state_d == S_DONE) && last_d;
            busy_q       <= (state_d != S_IDLE);
        end
    end

    assign sched_io.tile_ready = tile_ready_q;
    assign sched_io.load_en    = load_en_q;
    assign sched_io.fold_idx   = fold_q;
    assign sched_io.fold_nnz   = fold_nnz_q;
    assign sched_io.col_valid  = col_valid_q;
    assign sched_io.col_idx    = col_idx_q;
    assign sched_io.tile_done  = tile_done_q;
    assign sched_io.all_done   = all_done_q;
    assign sched_io.busy       = busy_q;
    assign sched_io.stall_cnt  = stall_q;
endmodule
